wheel_cmd_arbiter: RTL and testbench



---
 rtl/wheel_cmd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wheel_cmd_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wheel_cmd_arbiter.sv
// Purpose: shares the two signed wheel commands between estop, manual and auto, with priority, a manual watchdog and per-tick slew limiting.
// Latency: owner, targets and bb_enable update one clk after the inputs; wheel outputs move at most RAMP_STEP per tick (estop forces 0 on the next edge).
// Backpressure: none; sources are sampled every cycle and a losing source is simply ignored.
module wheel_cmd_arbiter #(
  parameter int RAMP_STEP      = 4,
  parameter int TICK_DIV       = 1000,
  parameter int MANUAL_TIMEOUT = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              estop,
  input  logic              auto_valid,
  input  logic signed [7:0] auto_left,
  input  logic signed [7:0] auto_right,
  input  logic              man_valid,
  input  logic signed [7:0] man_left,
  input  logic signed [7:0] man_right,
  output logic signed [7:0] wheel_left,
  output logic signed [7:0] wheel_right,
  output logic [1:0]        grant,
  output logic              bb_enable,
  output logic              man_timeout
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int WD_W  = $clog2(MANUAL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MANUAL_TIMEOUT - 1);
  localparam logic signed [8:0] STEP9   = 9'(RAMP_STEP);
  localparam logic signed [7:0] STEP8   = 8'(RAMP_STEP);

  // Encoding doubles as the grant code.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_AUTO   = 2'b01,
    ST_MANUAL = 2'b10,
    ST_ESTOP  = 2'b11
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [WD_W-1:0]   wd_cnt;
  logic              man_expire;
  logic signed [7:0] tgt_left, tgt_right;

  // -128 has no positive mirror, so clamp it to keep both directions symmetric.
  function automatic logic signed [7:0] sat_cmd(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh81 : v;
  endfunction

  // One slew step of an output toward its target; the 9-bit difference cannot overflow.
  function automatic logic signed [7:0] slew(input logic signed [7:0] out_v,
                                             input logic signed [7:0] tgt_v);
    logic signed [8:0] diff;
    diff = {tgt_v[7], tgt_v} - {out_v[7], out_v};
    if (diff > STEP9)
      return out_v + STEP8;
    else if (diff < -STEP9)
      return out_v - STEP8;
    else
      return tgt_v;
  endfunction

  assign tick  = (tick_cnt == CNT_LAST);
  assign grant = state;

  // Free-running tick divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  // Next owner: estop wins outright, manual beats auto, and only the watchdog ends manual.
  always_comb begin
    next_state = state;
    man_expire = 1'b0;
    if (estop) begin
      next_state = ST_ESTOP;
    end else begin
      case (state)
        ST_IDLE, ST_AUTO: begin
          if (man_valid)
            next_state = ST_MANUAL;
          else if (auto_valid)
            next_state = ST_AUTO;
          else
            next_state = ST_IDLE;
        end
        ST_MANUAL: begin
          if (!man_valid && tick && (wd_cnt == WD_LAST)) begin
            next_state = ST_IDLE;
            man_expire = 1'b1;
          end
        end
        ST_ESTOP: next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Owner register plus the outputs derived from the next owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bb_enable   <= 1'b0;
      man_timeout <= 1'b0;
    end else begin
      state       <= next_state;
      bb_enable   <= (next_state == ST_IDLE) || (next_state == ST_AUTO);
      man_timeout <= man_expire;
    end
  end

  // Manual watchdog: counts ticks without a manual strobe while manual owns the wheels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wd_cnt <= '0;
    else if ((next_state != ST_MANUAL) || man_valid)
      wd_cnt <= '0;
    else if (tick)
      wd_cnt <= wd_cnt + 1'b1;
  end

  // Targets follow the owner chosen on this edge, so an entering source is latched immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_left  <= '0;
      tgt_right <= '0;
    end else begin
      case (next_state)
        ST_AUTO: begin
          if (auto_valid) begin
            tgt_left  <= sat_cmd(auto_left);
            tgt_right <= sat_cmd(auto_right);
          end
        end
        ST_MANUAL: begin
          if (man_valid) begin
            tgt_left  <= sat_cmd(man_left);
            tgt_right <= sat_cmd(man_right);
          end
        end
        default: begin
          tgt_left  <= '0;
          tgt_right <= '0;
        end
      endcase
    end
  end

  // Wheel outputs slew toward the held targets on ticks; estop bypasses the ramp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wheel_left  <= '0;
      wheel_right <= '0;
    end else if (next_state == ST_ESTOP) begin
      wheel_left  <= '0;
      wheel_right <= '0;
    end else if (tick) begin
      wheel_left  <= slew(wheel_left, tgt_left);
      wheel_right <= slew(wheel_right, tgt_right);
    end
  end

endmodule

// File: tb/tb_wheel_cmd_arbiter.sv
// Purpose: directed test-plan scenarios plus random traffic, checked every cycle against a behavioural model of the arbiter.
// Latency: model advances once per clk and is compared half a cycle after each rising edge.
// Backpressure: not applicable; the bench drives every input each cycle.
module tb_wheel_cmd_arbiter;

  localparam int RS = 4;
  localparam int TD = 4;
  localparam int MT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              estop = 1'b0;
  logic              auto_valid = 1'b0;
  logic signed [7:0] auto_left = '0;
  logic signed [7:0] auto_right = '0;
  logic              man_valid = 1'b0;
  logic signed [7:0] man_left = '0;
  logic signed [7:0] man_right = '0;
  logic signed [7:0] wheel_left;
  logic signed [7:0] wheel_right;
  logic [1:0]        grant;
  logic              bb_enable;
  logic              man_timeout;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner 0 idle, 1 auto, 2 manual, 3 estop.
  int m_own, m_tl, m_tr, m_ol, m_or, m_cnt, m_wd, m_bbe, m_mto;
  int timeout_pulses;

  wheel_cmd_arbiter #(
    .RAMP_STEP(RS),
    .TICK_DIV(TD),
    .MANUAL_TIMEOUT(MT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .estop(estop),
    .auto_valid(auto_valid),
    .auto_left(auto_left),
    .auto_right(auto_right),
    .man_valid(man_valid),
    .man_left(man_left),
    .man_right(man_right),
    .wheel_left(wheel_left),
    .wheel_right(wheel_right),
    .grant(grant),
    .bb_enable(bb_enable),
    .man_timeout(man_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v == -128) ? -127 : v;
  endfunction

  function automatic int toward(input int o, input int t);
    int d;
    d = t - o;
    if (d > RS)  return o + RS;
    if (d < -RS) return o - RS;
    return t;
  endfunction

  task automatic model_reset();
    m_own = 0; m_tl = 0; m_tr = 0; m_ol = 0; m_or = 0;
    m_cnt = 0; m_wd = 0; m_bbe = 0; m_mto = 0;
  endtask

  task automatic compare_all();
    check("wheel_left",  int'(wheel_left),  m_ol);
    check("wheel_right", int'(wheel_right), m_or);
    check("grant",       int'(grant),       m_own);
    check("bb_enable",   int'(bb_enable),   m_bbe);
    check("man_timeout", int'(man_timeout), m_mto);
  endtask

  // One clk of stimulus: drive, let the DUT take the edge, advance the model, compare.
  task automatic step(input bit e, input bit av, input int al, input int ar,
                      input bit mv, input int ml, input int mr);
    int  nown;
    bit  tk;
    bit  to;
    estop      = e;
    auto_valid = av;
    auto_left  = 8'(al);
    auto_right = 8'(ar);
    man_valid  = mv;
    man_left   = 8'(ml);
    man_right  = 8'(mr);
    @(posedge clk);
    tk = (m_cnt == TD - 1);
    to = 1'b0;
    if (e)
      nown = 3;
    else if (m_own == 3)
      nown = 0;
    else if (m_own == 2) begin
      if (mv)
        nown = 2;
      else if (tk && (m_wd + 1 >= MT)) begin
        nown = 0;
        to   = 1'b1;
      end else
        nown = 2;
    end else
      nown = mv ? 2 : (av ? 1 : 0);
    // Outputs ramp toward the targets held before this edge.
    if (nown == 3) begin
      m_ol = 0; m_or = 0;
    end else if (tk) begin
      m_ol = toward(m_ol, m_tl);
      m_or = toward(m_or, m_tr);
    end
    if (nown == 1) begin
      m_tl = sat(al); m_tr = sat(ar);
    end else if (nown == 2) begin
      if (mv) begin
        m_tl = sat(ml); m_tr = sat(mr);
      end
    end else begin
      m_tl = 0; m_tr = 0;
    end
    if (nown != 2 || mv)
      m_wd = 0;
    else if (tk)
      m_wd = m_wd + 1;
    m_cnt = tk ? 0 : m_cnt + 1;
    m_bbe = (nown <= 1) ? 1 : 0;
    m_mto = to ? 1 : 0;
    m_own = nown;
    @(negedge clk);
    if (man_timeout === 1'b1) timeout_pulses++;
    compare_all();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    estop = 1'b0; auto_valid = 1'b0; man_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    int hit12;
    model_reset();
    timeout_pulses = 0;

    // Reset state.
    apply_reset();
    check("rst_grant", int'(grant), 0);
    check("rst_left",  int'(wheel_left), 0);

    // Auto ramp from reset release: left 4..20, right -4,-8,-10.
    step(0, 1, 20, -10, 0, 0, 0);
    check("auto_grant", int'(grant), 1);
    check("auto_bbe",   int'(bb_enable), 1);
    repeat (24) step(0, 1, 20, -10, 0, 0, 0);
    check("auto_left_settle",  int'(wheel_left), 20);
    check("auto_right_settle", int'(wheel_right), -10);

    // Handover to manual -8/8.
    step(0, 1, 20, -10, 1, -8, 8);
    check("man_grant", int'(grant), 2);
    check("man_bbe",   int'(bb_enable), 0);
    repeat (34) step(0, 1, 20, -10, 1, -8, 8);
    check("man_left_settle",  int'(wheel_left), -8);
    check("man_right_settle", int'(wheel_right), 8);

    // Watchdog expiry with auto waiting: manual must not yield to auto early.
    timeout_pulses = 0;
    repeat (8) step(0, 1, 20, -10, 0, 0, 0);
    check("wd_hold_grant", int'(grant), 2);
    repeat (12) step(0, 1, 20, -10, 0, 0, 0);
    check("wd_pulses", timeout_pulses, 1);
    check("wd_to_auto", int'(grant), 1);

    // Estop while the left output is mid-ramp at 12.
    hit12 = 0;
    for (int i = 0; i < 60 && !hit12; i++) begin
      step(0, 1, 40, 0, 0, 0, 0);
      if (wheel_left == 8'sd12) hit12 = 1;
    end
    check("reach_12", hit12, 1);
    step(1, 1, 40, 0, 0, 0, 0);
    check("estop_left",  int'(wheel_left), 0);
    check("estop_grant", int'(grant), 3);
    for (int i = 0; i < 10; i++) step(1, 1, 40, 0, i[0], 50, 50);
    check("estop_ignores_man", int'(grant), 3);
    step(0, 0, 0, 0, 0, 0, 0);
    check("estop_release", int'(grant), 0);
    step(0, 1, 30, 30, 0, 0, 0);
    check("resume_auto", int'(grant), 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Everything arriving together resolves to estop.
    step(1, 1, 10, 10, 1, 20, 20);
    check("all_rise_estop", int'(grant), 3);
    step(0, 0, 0, 0, 0, 0, 0);

    // -128 saturates to -127.
    repeat (200) step(0, 1, -128, 127, 0, 0, 0);
    check("sat_left",  int'(wheel_left), -127);
    check("sat_right", int'(wheel_right), 127);

    // Asynchronous reset between edges, mid-ramp.
    repeat (10) step(0, 1, 100, 100, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_left",  int'(wheel_left), 0);
    check("async_rst_right", int'(wheel_right), 0);
    check("async_rst_grant", int'(grant), 0);
    @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) != 0),
           int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128,
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
